// File: rtl/spi_frame_parser_pkg.sv
// rtl/spi_frame_parser_pkg.sv - shared SPI link opcodes, response bytes and framer states
package spi_link_pkg;

    localparam logic [7:0] CMD_WR     = 8'hA5;
    localparam logic [7:0] CMD_RD     = 8'h5A;
    localparam logic [7:0] ACK        = 8'hC3;
    localparam logic [7:0] NAK        = 8'hEE;
    localparam logic [7:0] STATUS_OK  = 8'h00;
    localparam logic [7:0] STATUS_BAD = 8'hFF;

    typedef enum logic [2:0] {
        CMD   = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/spi_frame_parser_if.sv
// rtl/spi_frame_parser_if.sv - byte stream, register port and response signals of the framer
interface spi_frame_parser_if;

    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_byte;
    logic       frame_ok;
    logic [7:0] err_cnt;

    modport slave (
        input  cs_n, rx_valid, rx_byte, rd_data,
        output wr_en, wr_addr, wr_data, rd_addr, tx_byte, frame_ok, err_cnt
    );

    modport master (
        output cs_n, rx_valid, rx_byte, rd_data,
        input  wr_en, wr_addr, wr_data, rd_addr, tx_byte, frame_ok, err_cnt
    );

endinterface

// File: rtl/spi_frame_parser.sv
// rtl/spi_frame_parser.sv - parses 4-byte write/read frames with XOR checksum on the SPI byte stream
module spi_frame_parser #(
    parameter logic [7:0] CMD_WR = spi_link_pkg::CMD_WR,
    parameter logic [7:0] CMD_RD = spi_link_pkg::CMD_RD,
    parameter logic [7:0] ACK    = spi_link_pkg::ACK,
    parameter logic [7:0] NAK    = spi_link_pkg::NAK
) (
    input  logic                sclk,
    input  logic                reset,
    spi_frame_parser_if.slave   bus
);
    import spi_link_pkg::*;

    state_t     state;
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] acc;
    logic       rd_fetch;

    logic       op_valid;
    logic       is_wr;
    logic [7:0] err_next;

    assign op_valid = (bus.rx_byte == CMD_WR) || (bus.rx_byte == CMD_RD);
    assign is_wr    = (opcode == CMD_WR);
    assign err_next = (bus.err_cnt == 8'hFF) ? bus.err_cnt : bus.err_cnt + 8'd1;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state        <= CMD;
            opcode       <= 8'h00;
            addr         <= 8'h00;
            data         <= 8'h00;
            acc          <= 8'h00;
            rd_fetch     <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= 8'h00;
            bus.wr_data  <= 8'h00;
            bus.rd_addr  <= 8'h00;
            bus.tx_byte  <= 8'h00;
            bus.frame_ok <= 1'b0;
            bus.err_cnt  <= 8'h00;
        end else begin
            bus.wr_en    <= 1'b0;
            bus.frame_ok <= 1'b0;
            if (bus.cs_n) begin
                // Deselect aborts the frame; any byte arriving on this edge is dropped.
                state    <= CMD;
                acc      <= 8'h00;
                rd_fetch <= 1'b0;
            end else begin
                if (rd_fetch) begin
                    bus.tx_byte <= bus.rd_data;
                    rd_fetch    <= 1'b0;
                end
                if (bus.rx_valid) begin
                    case (state)
                        CMD: begin
                            acc <= acc ^ bus.rx_byte;
                            if (op_valid) begin
                                opcode      <= bus.rx_byte;
                                bus.tx_byte <= ACK;
                                state       <= ADDR;
                            end else begin
                                bus.tx_byte <= NAK;
                                bus.err_cnt <= err_next;
                                state       <= DRAIN;
                            end
                        end
                        ADDR: begin
                            addr        <= bus.rx_byte;
                            bus.rd_addr <= bus.rx_byte;
                            acc         <= acc ^ bus.rx_byte;
                            // Reads return register data one edge later, once rd_data has settled.
                            if (is_wr) bus.tx_byte <= bus.rx_byte;
                            else       rd_fetch    <= 1'b1;
                            state       <= DATA;
                        end
                        DATA: begin
                            data        <= bus.rx_byte;
                            acc         <= acc ^ bus.rx_byte;
                            bus.tx_byte <= ~opcode;
                            state       <= CSUM;
                        end
                        CSUM: begin
                            if (acc == bus.rx_byte) begin
                                bus.frame_ok <= 1'b1;
                                bus.tx_byte  <= STATUS_OK;
                                if (is_wr) begin
                                    bus.wr_en   <= 1'b1;
                                    bus.wr_addr <= addr;
                                    bus.wr_data <= data;
                                end
                            end else begin
                                bus.tx_byte <= STATUS_BAD;
                                bus.err_cnt <= err_next;
                            end
                            state <= DRAIN;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_parser.sv
// tb/tb_spi_frame_parser.sv - directed and randomized frames checked against a frame-level reference model
module tb_spi_frame_parser;
    import spi_link_pkg::*;

    logic sclk = 1'b0;
    logic reset;

    spi_frame_parser_if sif();

    spi_frame_parser dut (
        .sclk  (sclk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 sclk = ~sclk;

    logic [7:0] rf [256];
    assign sif.rd_data = rf[sif.rd_addr];

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_tx;
    logic [7:0] exp_err;
    logic [7:0] exp_rd_addr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] tx0, output logic [7:0] tx1,
                             output logic we, output logic fo, output logic pulse_next,
                             output logic [7:0] wa, output logic [7:0] wd);
        @(negedge sclk);
        sif.rx_valid = 1'b1;
        sif.rx_byte  = b;
        @(posedge sclk);
        #1;
        tx0 = sif.tx_byte;
        we  = sif.wr_en;
        fo  = sif.frame_ok;
        wa  = sif.wr_addr;
        wd  = sif.wr_data;
        @(negedge sclk);
        sif.rx_valid = 1'b0;
        sif.rx_byte  = 8'($urandom);
        @(posedge sclk);
        #1;
        pulse_next = sif.wr_en | sif.frame_ok;
        repeat (6) @(posedge sclk);
        #1;
        tx1 = sif.tx_byte;
    endtask

    task automatic end_frame(input string tag);
        @(negedge sclk);
        sif.cs_n = 1'b1;
        repeat (3) @(negedge sclk);
        check({tag, "/cs_tx_hold"}, sif.tx_byte, exp_tx);
        check({tag, "/cs_err_hold"}, sif.err_cnt, exp_err);
        check({tag, "/cs_rdaddr_hold"}, sif.rd_addr, exp_rd_addr);
        sif.cs_n = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int n, input string tag);
        logic [7:0] f [4];
        logic       valid, wr, ok;
        logic [7:0] tx0, tx1, wa, wd;
        logic       we, fo, pn, exp_we, exp_fo;
        f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3;
        valid = (b0 == CMD_WR) || (b0 == CMD_RD);
        wr    = (b0 == CMD_WR);
        ok    = ((b0 ^ b1 ^ b2) == b3);
        for (int i = 0; i < n; i++) begin
            send_byte(f[i], tx0, tx1, we, fo, pn, wa, wd);
            exp_we = 1'b0;
            exp_fo = 1'b0;
            if (!valid) begin
                if (i == 0) begin
                    exp_tx  = NAK;
                    exp_err = sat_inc(exp_err);
                end
            end else begin
                case (i)
                    0: exp_tx = ACK;
                    1: begin
                        exp_rd_addr = b1;
                        exp_tx = wr ? b1 : rf[b1];
                        if (!wr) check({tag, "/rd_early"}, tx0, ACK);
                    end
                    2: exp_tx = ~b0;
                    default: begin
                        exp_fo = ok;
                        exp_we = ok && wr;
                        exp_tx = ok ? 8'h00 : 8'hFF;
                        if (!ok) exp_err = sat_inc(exp_err);
                    end
                endcase
            end
            check({tag, "/wr_en"}, we, exp_we);
            check({tag, "/frame_ok"}, fo, exp_fo);
            check({tag, "/pulse_width"}, pn, 1'b0);
            check({tag, "/tx"}, tx1, exp_tx);
            check({tag, "/err"}, sif.err_cnt, exp_err);
            check({tag, "/rd_addr"}, sif.rd_addr, exp_rd_addr);
            if (exp_we) begin
                check({tag, "/wr_addr"}, wa, b1);
                check({tag, "/wr_data"}, wd, b2);
                rf[b1] = b2;
            end
        end
        end_frame(tag);
    endtask

    initial begin
        logic [7:0] r0, r1, r2, r3;
        int         n;
        for (int i = 0; i < 256; i++) rf[i] = 8'($urandom);
        reset        = 1'b1;
        sif.cs_n     = 1'b1;
        sif.rx_valid = 1'b0;
        sif.rx_byte  = 8'h00;
        exp_tx       = 8'h00;
        exp_err      = 8'h00;
        exp_rd_addr  = 8'h00;
        repeat (3) @(negedge sclk);
        check("rst/tx", sif.tx_byte, 8'h00);
        check("rst/err", sif.err_cnt, 8'h00);
        check("rst/wr_en", sif.wr_en, 1'b0);
        check("rst/frame_ok", sif.frame_ok, 1'b0);
        check("rst/rd_addr", sif.rd_addr, 8'h00);
        check("rst/wr_addr", sif.wr_addr, 8'h00);
        reset    = 1'b0;
        @(negedge sclk);
        sif.cs_n = 1'b0;

        do_frame(8'hA5, 8'h10, 8'h3C, 8'h89, 4, "write");
        rf[8'h20] = 8'h99;
        do_frame(8'h5A, 8'h20, 8'h00, 8'h7A, 4, "read");
        do_frame(8'hA5, 8'h10, 8'h3C, 8'h00, 4, "bad_csum");
        do_frame(8'h77, 8'h11, 8'h22, 8'h33, 4, "bad_op");
        do_frame(8'hA5, 8'h33, 8'h44, 8'h00, 3, "truncated");
        do_frame(8'hA5, 8'h01, 8'h02, 8'hA6, 4, "after_trunc");

        // Byte arriving together with deselect must not start a frame.
        @(negedge sclk);
        sif.cs_n     = 1'b1;
        sif.rx_valid = 1'b1;
        sif.rx_byte  = 8'hA5;
        @(negedge sclk);
        sif.rx_valid = 1'b0;
        sif.cs_n     = 1'b0;
        do_frame(8'h5A, 8'h20, 8'h55, 8'h5A ^ 8'h20 ^ 8'h55, 4, "cs_wins");

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    r0 = CMD_WR;
                2:       r0 = CMD_RD;
                default: r0 = 8'($urandom);
            endcase
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (r0 ^ r1 ^ r2);
            n  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 4;
            do_frame(r0, r1, r2, r3, n, "rand");
        end

        for (int k = 0; k < 300; k++)
            do_frame(8'h77, 8'($urandom), 8'($urandom), 8'($urandom), 1, "sat");
        check("sat/final", sif.err_cnt, 8'hFF);

        begin
            logic [7:0] tx0, tx1, wa, wd;
            logic       we, fo, pn;
            send_byte(8'hA5, tx0, tx1, we, fo, pn, wa, wd);
            send_byte(8'h10, tx0, tx1, we, fo, pn, wa, wd);
        end
        @(negedge sclk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst/tx", sif.tx_byte, 8'h00);
        check("async_rst/err", sif.err_cnt, 8'h00);
        check("async_rst/rd_addr", sif.rd_addr, 8'h00);
        check("async_rst/wr_en", sif.wr_en, 1'b0);
        check("async_rst/frame_ok", sif.frame_ok, 1'b0);
        check("async_rst/wr_data", sif.wr_data, 8'h00);
        exp_tx      = 8'h00;
        exp_err     = 8'h00;
        exp_rd_addr = 8'h00;
        sif.cs_n    = 1'b1;
        @(negedge sclk);
        reset    = 1'b0;
        @(negedge sclk);
        sif.cs_n = 1'b0;
        do_frame(8'hA5, 8'h42, 8'h17, 8'hA5 ^ 8'h42 ^ 8'h17, 4, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
